// File: rtl/commit_ctrl.sv
// In-order commit sequencer: retires the ROB head, drives the register file update port,
// runs the store handshake and turns a mispredicted branch into a one-cycle flush.
module commit_ctrl #(
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic [ROB_IDX_W-1:0] head_idx,
    input  logic [1:0]           head_type,
    input  logic [4:0]           head_rd,
    input  logic [31:0]          head_val,
    input  logic                 head_mispred,
    input  logic [31:0]          head_target,
    input  logic                 st_ack,
    output logic                 rob_pop,
    output logic                 run_upd,
    output logic [4:0]           commit_rd,
    output logic [31:0]          res,
    output logic [ROB_IDX_W-1:0] head,
    output logic                 st_req,
    output logic                 flush,
    output logic [31:0]          flush_pc,
    output logic [31:0]          commit_cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_ST_WAIT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic                 r_st_req;
    logic                 w_st_req_nxt;
    logic                 r_flush;
    logic                 w_flush_nxt;
    logic [31:0]          r_flush_pc;
    logic [31:0]          w_flush_pc_nxt;
    logic [31:0]          r_commit_cnt;
    logic                 w_pop;
    logic                 w_upd;
    logic [4:0]           w_rd;
    logic [31:0]          w_res;
    logic [ROB_IDX_W-1:0] w_head;

    always_comb begin
        w_state_nxt    = r_state;
        w_st_req_nxt   = r_st_req;
        w_flush_nxt    = r_flush;
        w_flush_pc_nxt = r_flush_pc;
        w_pop          = 1'b0;
        w_upd          = 1'b0;
        w_rd           = '0;
        w_res          = '0;
        w_head         = '0;
        // Reset and a stalled pipeline both suppress every strobe and freeze state.
        if (!rst && rdy) begin
            case (r_state)
                S_RUN: begin
                    if (head_valid && head_ready) begin
                        if (head_type == 2'd1) begin
                            w_state_nxt  = S_ST_WAIT;
                            w_st_req_nxt = 1'b1;
                        end else begin
                            w_pop  = 1'b1;
                            w_upd  = (head_rd != 5'd0);
                            w_rd   = head_rd;
                            w_res  = head_val;
                            w_head = head_idx;
                            // Link write retires now; the flush follows one cycle later.
                            if (head_type == 2'd2 && head_mispred) begin
                                w_state_nxt    = S_FLUSH;
                                w_flush_nxt    = 1'b1;
                                w_flush_pc_nxt = head_target;
                            end
                        end
                    end
                end
                S_ST_WAIT: begin
                    if (st_ack) begin
                        w_pop        = 1'b1;
                        w_head       = head_idx;
                        w_st_req_nxt = 1'b0;
                        w_state_nxt  = S_RUN;
                    end
                end
                S_FLUSH: begin
                    w_flush_nxt = 1'b0;
                    w_state_nxt = S_RUN;
                end
                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_st_req     <= 1'b0;
            r_flush      <= 1'b0;
            r_flush_pc   <= '0;
            r_commit_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_st_req   <= w_st_req_nxt;
            r_flush    <= w_flush_nxt;
            r_flush_pc <= w_flush_pc_nxt;
            if (w_pop) begin
                r_commit_cnt <= r_commit_cnt + 32'd1;
            end
        end
    end

    assign rob_pop    = w_pop;
    assign run_upd    = w_upd;
    assign commit_rd  = w_rd;
    assign res        = w_res;
    assign head       = w_head;
    assign st_req     = r_st_req;
    assign flush      = r_flush;
    assign flush_pc   = r_flush_pc;
    assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_commit_ctrl.sv
// Scoreboard bench for commit_ctrl: directed scenarios then randomized traffic,
// expected behaviour predicted by a behavioural model and checked by an independent monitor.
module tb_commit_ctrl;
    localparam int W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, rdy = 1'b0, head_valid = 1'b0, head_ready = 1'b0;
    logic [W-1:0]  head_idx = '0;
    logic [1:0]    head_type = '0;
    logic [4:0]    head_rd = '0;
    logic [31:0]   head_val = '0, head_target = '0;
    logic          head_mispred = 1'b0, st_ack = 1'b0;
    logic          rob_pop, run_upd, st_req, flush;
    logic [4:0]    commit_rd;
    logic [31:0]   res, flush_pc, commit_cnt;
    logic [W-1:0]  head;

    commit_ctrl #(.ROB_IDX_W(W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .head_valid(head_valid), .head_ready(head_ready),
        .head_idx(head_idx), .head_type(head_type), .head_rd(head_rd), .head_val(head_val),
        .head_mispred(head_mispred), .head_target(head_target), .st_ack(st_ack),
        .rob_pop(rob_pop), .run_upd(run_upd), .commit_rd(commit_rd), .res(res), .head(head),
        .st_req(st_req), .flush(flush), .flush_pc(flush_pc), .commit_cnt(commit_cnt)
    );

    typedef struct packed {
        logic         pop;
        logic         upd;
        logic [4:0]   rd;
        logic [31:0]  res;
        logic [W-1:0] hd;
        logic         st_req;
        logic         flush;
        logic [31:0]  flush_pc;
        logic [31:0]  cnt;
    } cyc_t;

    typedef struct packed {
        int           cyc;
        logic         store;
        logic         upd;
        logic [4:0]   rd;
        logic [31:0]  res;
        logic [W-1:0] hd;
    } com_t;

    cyc_t cyc_q[$];
    com_t com_q[$];
    int checks = 0;
    int errors = 0;
    int scyc = 0;

    // Behavioural model: a store awaiting its ack, a flush due this cycle, and the retire count.
    bit          m_store_pending = 0;
    bit          m_flush_now = 0;
    logic [31:0] m_flush_pc = '0;
    logic [31:0] m_cnt = '0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic i_rst, input logic i_rdy, input logic i_hv, input logic i_hr,
                        input logic [1:0] i_t, input logic [4:0] i_rd, input logic [31:0] i_val,
                        input logic [W-1:0] i_idx, input logic i_mp, input logic [31:0] i_tgt,
                        input logic i_ack);
        cyc_t e;
        com_t c;
        @(negedge clk);
        rst = i_rst; rdy = i_rdy; head_valid = i_hv; head_ready = i_hr; head_type = i_t;
        head_rd = i_rd; head_val = i_val; head_idx = i_idx; head_mispred = i_mp;
        head_target = i_tgt; st_ack = i_ack;
        e = '0;
        c = '0;
        e.st_req   = m_store_pending;
        e.flush    = m_flush_now;
        e.flush_pc = m_flush_pc;
        e.cnt      = m_cnt;
        c.cyc      = scyc;
        if (!i_rst && i_rdy) begin
            if (m_flush_now) begin
                m_flush_now = 0;
            end else if (m_store_pending) begin
                if (i_ack) begin
                    e.pop = 1'b1; e.hd = i_idx;
                    c.store = 1'b1; c.hd = i_idx;
                    com_q.push_back(c);
                    m_store_pending = 0;
                end
            end else if (i_hv && i_hr) begin
                if (i_t == 2'd1) begin
                    m_store_pending = 1;
                end else begin
                    e.pop = 1'b1; e.upd = (i_rd != 0); e.rd = i_rd; e.res = i_val; e.hd = i_idx;
                    c.upd = e.upd; c.rd = i_rd; c.res = i_val; c.hd = i_idx;
                    com_q.push_back(c);
                    if (i_t == 2'd2 && i_mp) begin
                        m_flush_now = 1;
                        m_flush_pc  = i_tgt;
                    end
                end
            end
        end
        if (e.pop) m_cnt = m_cnt + 1;
        if (i_rst) begin
            m_store_pending = 0; m_flush_now = 0; m_flush_pc = '0; m_cnt = '0;
        end
        cyc_q.push_back(e);
        scyc++;
    endtask

    // Monitor: compares every cycle's outputs, and each DUT pop against the commit queue.
    initial begin : monitor
        cyc_t e;
        com_t c;
        int mcyc;
        mcyc = 0;
        forever begin
            @(negedge clk);
            #2;
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                chk("rob_pop", mcyc, {31'd0, rob_pop}, {31'd0, e.pop});
                chk("run_upd", mcyc, {31'd0, run_upd}, {31'd0, e.upd});
                chk("commit_rd", mcyc, {27'd0, commit_rd}, {27'd0, e.rd});
                chk("res", mcyc, res, e.res);
                chk("head", mcyc, {{(32-W){1'b0}}, head}, {{(32-W){1'b0}}, e.hd});
                chk("st_req", mcyc, {31'd0, st_req}, {31'd0, e.st_req});
                chk("flush", mcyc, {31'd0, flush}, {31'd0, e.flush});
                chk("commit_cnt", mcyc, commit_cnt, e.cnt);
                if (e.flush) chk("flush_pc", mcyc, flush_pc, e.flush_pc);
                if (rob_pop === 1'b1) begin
                    if (com_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop cycle %0d got pop expected none", mcyc);
                    end else begin
                        c = com_q.pop_front();
                        chk("commit_cycle", mcyc, mcyc, c.cyc);
                        chk("commit_upd", mcyc, {31'd0, run_upd}, {31'd0, c.upd});
                        if (!c.store) begin
                            chk("commit_rd_val", mcyc, {27'd0, commit_rd}, {27'd0, c.rd});
                            chk("commit_res", mcyc, res, c.res);
                        end
                    end
                end
                mcyc++;
            end
        end
    end

    initial begin : stimulus
        // rst rdy hv hr type rd val idx mp tgt ack
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // back-to-back ALU commits, then rd=0
        step(0, 1, 1, 1, 0, 5, 32'h12cc, 3, 0, 0, 0);
        step(0, 1, 1, 1, 0, 6, 32'h1, 4, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 32'hdead, 5, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // store with ack delayed 3 cycles
        step(0, 1, 1, 1, 1, 0, 0, 6, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 6, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 6, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 6, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 6, 0, 0, 1);
        // mispredicted branch with head still ready during the flush
        step(0, 1, 1, 1, 2, 1, 32'h104, 7, 1, 32'h200, 0);
        step(0, 1, 1, 1, 0, 2, 32'h55, 8, 0, 0, 0);
        step(0, 1, 1, 1, 0, 2, 32'h55, 8, 0, 0, 0);
        // rdy low with a ready head, then a store whose ack arrives while stalled
        step(0, 0, 1, 1, 0, 9, 32'h99, 9, 0, 0, 0);
        step(0, 0, 1, 1, 0, 9, 32'h99, 9, 0, 0, 0);
        step(0, 1, 1, 1, 0, 9, 32'h99, 9, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 10, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0, 0, 10, 0, 0, 1);
        step(0, 0, 1, 1, 1, 0, 0, 10, 0, 0, 1);
        step(0, 1, 1, 1, 1, 0, 0, 10, 0, 0, 1);
        // reset while waiting for a store ack; the late ack must be ignored
        step(0, 1, 1, 1, 1, 0, 0, 11, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 11, 0, 0, 0);
        step(1, 1, 1, 1, 1, 0, 0, 11, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_rdy, r_hv, r_hr, r_mp, r_ack;
            logic [1:0] r_t;
            logic [4:0] r_rd;
            r_rst = ($urandom_range(0, 149) == 0);
            r_rdy = ($urandom_range(0, 99) < 85);
            r_hv  = ($urandom_range(0, 99) < 80);
            r_hr  = ($urandom_range(0, 99) < 70);
            r_t   = 2'($urandom_range(0, 3));
            r_rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r_mp  = ($urandom_range(0, 3) == 0);
            r_ack = ($urandom_range(0, 99) < 30);
            step(r_rst, r_rdy, r_hv, r_hr, r_t, r_rd, $urandom, W'($urandom), r_mp, $urandom, r_ack);
        end
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #5;
        checks++;
        if (com_q.size() != 0) begin
            errors++;
            $display("FAIL commit_q_drain got %0d pending expected 0", com_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_ctrl.md
# commit_ctrl

In-order commit sequencer between the ROB head and the renamed register file. Each cycle it checks the ROB head entry, retires it when it is ready, and drives the register file's update port (`run_upd`/`commit_rd`/`res`/`head`). It also runs the store-to-memory handshake and converts a mispredicted branch into a one-cycle pipeline `reset` (flush) with a redirect PC.

## Interface
- `ROB_IDX_W`, default 5: ROB tag width (`ROB_SZ_LOG`+1); tag 0 means "no tag".
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `rdy`  in  1: when low, the block freezes (no state change, all commit strobes low).
- `head_valid`  in  1: ROB is non-empty.
- `head_ready`  in  1: head result is available.
- `head_idx`  in  ROB_IDX_W: tag of the head entry.
- `head_type`  in  2: 0 = ALU/load writing rd, 1 = store, 2 = branch/jump, 3 = reserved (treated as 0).
- `head_rd`  in  5: destination register; 0 means no write.
- `head_val`  in  32: result value (branch: link value).
- `head_mispred`  in  1: branch outcome differs from prediction.
- `head_target`  in  32: correct PC for a mispredicted branch.
- `st_ack`  in  1: memory controller has completed the store.
- `rob_pop`  out  1: ROB advances its head at the next edge.
- `run_upd`  out  1: register file update strobe.
- `commit_rd`  out  5: register to update.
- `res`  out  32: value to write.
- `head`  out  ROB_IDX_W: tag being retired (register file compares it against Reordered).
- `st_req`  out  1: store request, registered.
- `flush`  out  1: drives the register file, ROB and RS `reset`; registered.
- `flush_pc`  out  32: redirect PC, valid while `flush`=1.
- `commit_cnt`  out  32: number of retired instructions.

## Operation
- The state machine has three states: RUN, ST_WAIT and FLUSH. Reset puts it in RUN.
- **RUN**, with `rdy`=1, `head_valid`=1 and `head_ready`=1:
  - type 0: `rob_pop`=1 in the same cycle (combinational). `run_upd`=1 when `head_rd`≠0. `commit_rd`=`head_rd`, `res`=`head_val`, `head`=`head_idx`. The state stays in RUN.
  - type 1: no pop. `st_req` is set at the next edge and the state goes to ST_WAIT.
  - type 2: pop and register update as for type 0. If `head_mispred`=1:
    - at the next edge, `flush`←1, `flush_pc`←`head_target`, and the state goes to FLUSH;
    - the rd write and the flush fall in separate cycles, so the link write is not lost to the register file's reset priority.
- **ST_WAIT**:
  - `st_req` is held at 1 until `st_ack` arrives.
  - In the `st_ack`=1 cycle: `rob_pop`=1 (combinational), `run_upd`=0. At the next edge, `st_req`←0 and the state goes to RUN.
- **FLUSH**:
  - `flush`=1 for exactly this one cycle. No pops and no updates.
  - At the next edge, `flush`←0 and the state goes to RUN.
- When not committing, `run_upd`=0, `rob_pop`=0, and `commit_rd`, `res` and `head` are 0.
- `commit_cnt` increments by 1 on every edge where `rob_pop`=1 and `rdy`=1. It wraps modulo 2^32.
- **Reset**: state=RUN; `st_req`=0, `flush`=0, `flush_pc`=0, `commit_cnt`=0. All combinational outputs are 0. Reset during ST_WAIT drops `st_req`; a later `st_ack` is ignored.
- **rdy=0**: all combinational strobes are forced to 0, and state and registers hold. `st_ack` arriving while `rdy`=0 is not taken; the memory side holds `st_ack` until it is accepted.
- `head_valid`=0 or `head_ready`=0 in RUN: idle, outputs 0.

## Timing
- Type 0 and type 2 commits take zero cycles: the register file write and the ROB pop happen at the same edge. Throughput is 1 commit/cycle.
- Store commit sequence:
  - edge E0: the store is seen in RUN and `st_req`←1;
  - cycle with `st_ack`: pop;
  - minimum store latency is 2 cycles if `st_ack` returns in the first ST_WAIT cycle.
- Mispredict sequence:
  - cycle k: branch pop and link write;
  - cycle k+1: `flush`=1;
  - cycle k+2: RUN, and the ROB is empty after the flush.
- Reset takes priority over `rdy`; `rdy` takes priority over everything else.

## Test plan
- Back-to-back type 0 heads (rd=5, val=0x12cc, idx=3; then rd=6, val=0x1, idx=4), each ready → `run_upd`/`rob_pop` high in 2 consecutive cycles with the matching rd/res/head; `commit_cnt`=2.
- Type 0 with rd=0 → `rob_pop`=1, `run_upd`=0.
- Store head with `st_ack` delayed 3 cycles → `st_req`=1 for 4 cycles, `rob_pop` only in the ack cycle, `run_upd` never high.
- Branch with `head_mispred`=1, rd=1, val=0x104, target=0x200 →
  - cycle k: `run_upd`=1 with res=0x104;
  - cycle k+1: `flush`=1 with `flush_pc`=0x200 and no pop, even though the head is still ready;
  - cycle k+2: commits resume.
- `rdy`=0 for 2 cycles with a ready head and an `st_ack` pulse → no strobes, no counter change; commit proceeds once `rdy`=1.
- `rst` asserted in ST_WAIT → next cycle `st_req`=0, state RUN, `commit_cnt`=0.
